dwell_timer: RTL

- Loadable down-counting timer, complementary to the free-running wrap-around up-counter. The up-counter acts as prescaler and produces a one-cycle tick each time it wraps.
- This block consumes those ticks to time elevator intervals such as door dwell and floor-arrival settle.
- It supports start, restart/extend, hold and cancel, and emits a single-cycle expiry pulse to the controller FSM.

---
 rtl/dwell_timer.sv | 93 +++++++++
 1 files changed

// File: rtl/dwell_timer.sv
// Loadable down-counting dwell timer driven by prescaler ticks.
// Supports start/extend, hold, cancel and a single-cycle expiry pulse.
module dwell_timer #(
    parameter int WIDTH        = 8,
    parameter int DEFAULT_LOAD = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             cancel,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             expired,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2,
        UNUSED = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] DefaultLoad = WIDTH'(DEFAULT_LOAD);
    localparam logic [WIDTH-1:0] One         = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] eff_load;

    assign eff_load = (load_val == '0) ? DefaultLoad : load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Priority is cancel > start > tick; hold only gates the tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (!cancel && start) begin
                    state_d = RUN;
                    rem_d   = eff_load;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (start) begin
                    rem_d = eff_load;
                end else if (tick_en && !hold) begin
                    if (rem_q > One) begin
                        rem_d = rem_q - One;
                    end else begin
                        state_d = DONE;
                        rem_d   = '0;
                    end
                end
            end
            DONE: begin
                if (!cancel && start) begin
                    state_d = RUN;
                    rem_d   = eff_load;
                end else begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    assign remaining = rem_q;
    assign busy      = (state_q == RUN);
    assign expired   = (state_q == DONE);
    assign state     = state_q;

endmodule
